// File: rtl/tb_mem_multi_port.sv
// Multi-port byte-addressed behavioural RAM with round-robin req/ack arbitration and wait states.
// Optional macro TB_MEM_ALIGN_CHECK_EN: misaligned 16-bit accesses fault instead of being aligned down.
module tb_mem_multi_port #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                             tb_clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [NUM_PORTS-1:0]             acc_sz,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*16-1:0]          wdata,
    output logic [NUM_PORTS-1:0]             ack,
    output logic [15:0]                      rdata,
    output logic                             err,
    output logic                             busy
);

    localparam int unsigned MemAw = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned IdxW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            we_q, we_d;
    logic            sz_q, sz_d;
    logic [MemAw-1:0] addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            gnt_vld;
    logic [IdxW-1:0] gnt_idx;
    logic [IdxW:0]   arb_sum;
    logic [MemAw-1:0] a_hi, a_lo;
    logic            fault;

    // Only the low MemAw address bits select storage; the rest wrap away.
    logic unused_addr;
    assign unused_addr = ^addr;

    // Rotating priority: scan from rr_ptr upward, wrapping at NUM_PORTS.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_sum = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            arb_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (arb_sum >= (IdxW+1)'(NUM_PORTS)) begin
                arb_sum = arb_sum - (IdxW+1)'(NUM_PORTS);
            end
            if (!gnt_vld && req[arb_sum[IdxW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = arb_sum[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        sz_d       = sz_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_vld) begin
                    idx_d      = gnt_idx;
                    we_d       = we[gnt_idx];
                    sz_d       = acc_sz[gnt_idx];
                    addr_d     = addr[32'(gnt_idx) * ADDR_WIDTH +: MemAw];
                    wdata_d    = wdata[32'(gnt_idx) * 16 +: 16];
                    wait_cnt_d = '0;
                    state_d    = (WAIT_STATES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'(WAIT_STATES - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StResp: begin
                state_d  = StIdle;
                rr_ptr_d = (idx_q == IdxW'(NUM_PORTS - 1)) ? '0 : idx_q + IdxW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // Big-endian: the high byte lives at the lower address.
    always_comb begin
        a_hi = addr_q;
`ifdef TB_MEM_ALIGN_CHECK_EN
        fault = sz_q & addr_q[0];
`else
        fault = 1'b0;
        if (sz_q) begin
            a_hi[0] = 1'b0;
        end
`endif
        a_lo = a_hi + MemAw'(1);
    end

    always_comb begin
        ack   = '0;
        rdata = 16'h0000;
        err   = 1'b0;
        busy  = (state_q != StIdle);
        if (state_q == StResp) begin
            ack[idx_q] = 1'b1;
            err        = fault;
            if (!we_q && !fault) begin
                rdata = sz_q ? {mem[a_hi], mem[a_lo]} : {8'h00, mem[a_hi]};
            end
        end
    end

    always_ff @(posedge tb_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            sz_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            sz_q       <= sz_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Storage is deliberately not cleared by reset; a reset in flight drops the write.
    always_ff @(posedge tb_clk) begin
        if (!reset && state_q == StResp && we_q && !fault) begin
            if (sz_q) begin
                mem[a_hi] <= wdata_q[15:8];
                mem[a_lo] <= wdata_q[7:0];
            end else begin
                mem[a_hi] <= wdata_q[7:0];
            end
        end
    end

endmodule
